// File: rtl/knowles_sub_pipe.sv
// Two-stage pipelined 26-bit subtractor (a - b - bin) built on a Knowles prefix carry tree.
// Optional registered two's-complement overflow output enabled by macro KNOWLES_SUB_OVF_EN.
module knowles_sub_pipe #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef KNOWLES_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Prefix position 0 is the carry-in (g = ~bin, p = 0); position i+1 is operand bit i.
    localparam int N = WIDTH + 1;

    // One row of black cells. Shifting in zeros turns low positions into pass-through,
    // and since p[0] = 0 every group reaching position 0 has P = 0 (grey behaviour).
    function automatic logic [2*N-1:0] prefix_level(input logic [N-1:0] g,
                                                    input logic [N-1:0] p,
                                                    input int           span);
        return {g | (p & (g << span)), p & (p << span)};
    endfunction

    logic             out_en, s1_en;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [N-1:0]     g3_q, g3_d, p3_q, p3_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic [WIDTH-1:0] nb, p_in;
    logic [N-1:0]     g0, p0, g1, p1, g2, p2, g3, p3;
    logic [N-1:0]     g4, p4, gf;

    // Stage 1: propagate/generate and prefix levels with spans 1, 2, 4.
    always_comb begin
        nb   = ~b;
        p_in = a ^ nb;
        g0   = {a & nb, ~bin};
        p0   = {p_in, 1'b0};
        {g1, p1} = prefix_level(g0, p0, 1);
        {g2, p2} = prefix_level(g1, p1, 2);
        {g3, p3} = prefix_level(g2, p2, 4);
    end

    // Stage 2: spans 8 and 16; only G is needed after the last row.
    always_comb begin
        {g4, p4} = prefix_level(g3_q, p3_q, 8);
        gf       = g4 | (p4 & (g4 << 16));
    end

    always_comb begin
        out_en   = !out_valid_q || out_ready;
        s1_en    = !s1_valid_q || out_en;
        in_ready = s1_en;

        s1_valid_d = s1_en ? in_valid : s1_valid_q;
        p_d        = p_q;
        g3_d       = g3_q;
        p3_d       = p3_q;
        if (s1_en && in_valid) begin
            p_d  = p_in;
            g3_d = g3;   // g3_d[0] carries ~bin into the second stage
            p3_d = p3;
        end

        out_valid_d = out_en ? s1_valid_q : out_valid_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        if (out_en && s1_valid_q) begin
            diff_d = p_q ^ gf[WIDTH-1:0];
            bout_d = ~gf[WIDTH];
        end
    end

`ifdef KNOWLES_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB differs from carry out exactly when the signed result wraps.
    always_comb begin
        ovf_d = ovf_q;
        if (out_en && s1_valid_q)
            ovf_d = gf[WIDTH-1] ^ gf[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
        end
    end

    // Stage-1 data is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        p_q  <= p_d;
        g3_q <= g3_d;
        p3_q <= p3_d;
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_knowles_sub_pipe.sv
// Randomized and directed self-checking bench for knowles_sub_pipe against an arithmetic model.
`timescale 1ns/1ps
module tb_knowles_sub_pipe;
    localparam int W = 26;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    wire          in_ready, out_valid, bout;
    wire  [W-1:0] diff;
`ifdef KNOWLES_SUB_OVF_EN
    wire          ovf;
`endif

    knowles_sub_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef KNOWLES_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } res_t;

    int   vectors = 0;
    int   miscompares = 0;
    res_t sb[$];

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        res_t       r;
        logic [W:0] full;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        r.d  = full[W-1:0];
        r.bo = full[W];
        r.ov = (x[W-1] != y[W-1]) && (r.d[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = W'($urandom()); b = W'($urandom()); bin = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            a = W'($urandom());
            #1;
            vectors++;
            if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: out_valid=%b diff=%h bout=%b, want 0/0/0", out_valid, diff, bout);
            end
`ifdef KNOWLES_SUB_OVF_EN
            vectors++;
            if (ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ovf: got %b want 0", ovf);
            end
`endif
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_inputs_ignored: out_valid=%b want 0", out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{26'h0000005, 26'h0000000, 26'h2000000, 26'h1555555};
        logic [W-1:0] tb [4] = '{26'h0000003, 26'h0000001, 26'h0000001, 26'h1555555};
        logic         tbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] td [4] = '{26'h0000002, 26'h3FFFFFF, 26'h1FFFFFF, 26'h3FFFFFF};
        logic         tbo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic         tov[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = ta[k]; b = tb[k]; bin = tbi[k];
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL directed_ready[%0d]: got %b want 1", k, in_ready);
            end
            tick();
            in_valid = 1'b0; a = W'($urandom());
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_latency1[%0d]: out_valid=%b want 0", k, out_valid);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || diff !== td[k] || bout !== tbo[k]) begin
                miscompares++;
                $display("FAIL directed[%0d]: valid=%b diff=%h bout=%b, want 1 %h %b",
                         k, out_valid, diff, bout, td[k], tbo[k]);
            end
`ifdef KNOWLES_SUB_OVF_EN
            vectors++;
            if (ovf !== tov[k]) begin
                miscompares++;
                $display("FAIL directed_ovf[%0d]: got %b want %b", k, ovf, tov[k]);
            end
`else
            if (tov[k] === 1'bx) $display("unused");
`endif
            tick();
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_q[8];
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                in_valid = 1'b1; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom());
                exp_q[k] = model(a, b, bin);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k < 8) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready);
                end
            end
            vectors++;
            if (k >= 2) begin
                if (out_valid !== 1'b1 || diff !== exp_q[k-2].d || bout !== exp_q[k-2].bo) begin
                    miscompares++;
                    $display("FAIL b2b_out[%0d]: valid=%b diff=%h bout=%b, want 1 %h %b",
                             k, out_valid, diff, bout, exp_q[k-2].d, exp_q[k-2].bo);
                end
            end else if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_early[%0d]: out_valid=%b want 0", k, out_valid);
            end
            tick();
        end
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        res_t         r[3];
        logic [W-1:0] held;
        int           acc = 0;
        logic [W-1:0] oa[3];
        logic [W-1:0] ob[3];
        for (int k = 0; k < 3; k++) begin
            oa[k] = W'($urandom()); ob[k] = W'($urandom()) ^ W'(k + 1);
            r[k]  = model(oa[k], ob[k], 1'b0);
        end
        held = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = oa[(k > 2) ? 2 : k]; b = ob[(k > 2) ? 2 : k]; bin = 1'b0;
            #1;
            if (k >= 2) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_ready_low[%0d]: got %b want 0", k, in_ready);
                end
            end
            if (in_ready === 1'b1) acc++;
            if (k == 2) begin
                vectors++;
                if (out_valid !== 1'b1 || diff !== r[0].d) begin
                    miscompares++;
                    $display("FAIL bp_first: valid=%b diff=%h want 1 %h", out_valid, diff, r[0].d);
                end
                held = diff;
            end
            if (k == 3) begin
                vectors++;
                if (out_valid !== 1'b1 || diff !== held) begin
                    miscompares++;
                    $display("FAIL bp_stable: valid=%b diff=%h want 1 %h", out_valid, diff, held);
                end
            end
            tick();
        end
        vectors++;
        if (acc !== 2) begin
            miscompares++;
            $display("FAIL bp_accept_count: got %0d want 2", acc);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (k < 2) begin
                if (out_valid !== 1'b1 || diff !== r[k].d || bout !== r[k].bo) begin
                    miscompares++;
                    $display("FAIL bp_order[%0d]: valid=%b diff=%h bout=%b want 1 %h %b",
                             k, out_valid, diff, bout, r[k].d, r[k].bo);
                end
            end else if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        res_t r;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom());
            #1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mrst_inflight: out_valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mrst_state: valid=%b diff=%h bout=%b in_ready=%b want 0 0 0 1",
                     out_valid, diff, bout, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mrst_ghost[%0d]: out_valid=%b want 0", k, out_valid);
            end
        end
        in_valid = 1'b1; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom());
        r = model(a, b, bin);
        #1;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || diff !== r.d || bout !== r.bo) begin
            miscompares++;
            $display("FAIL mrst_resume: valid=%b diff=%h bout=%b want 1 %h %b",
                     out_valid, diff, bout, r.d, r.bo);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] corners[4] = '{26'h0000000, 26'h3FFFFFF, 26'h2000000, 26'h1FFFFFF};
        logic         prev_stall = 1'b0;
        logic [W-1:0] prev_diff = '0;
        res_t         e;
        sb.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            a   = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : W'($urandom());
            b   = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : W'($urandom());
            bin = 1'($urandom());
            #1;
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || diff !== prev_diff) begin
                    miscompares++;
                    $display("FAIL rand_hold[%0d]: valid=%b diff=%h want 1 %h", cyc, out_valid, diff, prev_diff);
                end
            end
            if (in_valid && in_ready === 1'b1) sb.push_back(model(a, b, bin));
            if (out_valid === 1'b1 && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra[%0d]: unexpected result diff=%h", cyc, diff);
                end else begin
                    e = sb.pop_front();
                    if (diff !== e.d || bout !== e.bo) begin
                        miscompares++;
                        $display("FAIL rand_data[%0d]: diff=%h bout=%b want %h %b", cyc, diff, bout, e.d, e.bo);
                    end
`ifdef KNOWLES_SUB_OVF_EN
                    vectors++;
                    if (ovf !== e.ov) begin
                        miscompares++;
                        $display("FAIL rand_ovf[%0d]: got %b want %b", cyc, ovf, e.ov);
                    end
`endif
                end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_diff  = diff;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (out_valid === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_drain_extra: diff=%h", diff);
                end else begin
                    e = sb.pop_front();
                    if (diff !== e.d || bout !== e.bo) begin
                        miscompares++;
                        $display("FAIL rand_drain: diff=%h bout=%b want %h %b", diff, bout, e.d, e.bo);
                    end
                end
            end
            tick();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rand_lost: %0d results never emerged", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
